// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and helpers for the memory/write-back stage.
//   - funct3 access-size encodings (F3_*)
//   - FSM state encoding (ST_IDLE, ST_REQ)
//   - byte-strobe base patterns (STRB_*)
//   - is_aligned()   : alignment / legality check of an access
//   - byte_strobe()  : byte-enable pattern for an access at a given offset
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    // funct3=111 has no defined size; it is reported as not aligned so the
    // stage rejects it exactly like a misaligned access.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] off);
        logic ok;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = (off[0] == 1'b0);
            F3_W, F3_WU: ok = (off[1:0] == 2'b00);
            F3_D:        ok = (off == 3'b000);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only called for aligned accesses, so the shift never pushes set bits out.
    function automatic logic [7:0] byte_strobe(input logic [2:0] f3, input logic [2:0] off);
        logic [7:0] s;
        case (f3[1:0])
            2'b00:   s = STRB_B << off;
            2'b01:   s = STRB_H << off;
            2'b10:   s = STRB_W << off;
            default: s = STRB_D;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: word-addressed data-memory request/ready bus.
//   mem_req   : request valid (master -> slave)
//   mem_we    : 1 = write
//   mem_addr  : 8-byte aligned word address
//   mem_wdata : store data already shifted to its byte lane
//   mem_wstrb : byte enables
//   mem_ready : request accepted this cycle; mem_rdata valid in the same cycle
//   mem_rdata : read word
interface mem_stage_if #(
    parameter int XLEN = 64
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wstrb;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage_load_extract.sv
// load_extract: combinational byte-lane extraction for loads.
//   i_rdata  : 64-bit word returned by memory
//   i_off    : byte offset of the access inside the word
//   i_funct3 : access size / signedness
//   o_data   : selected lane, sign-extended for B/H/W, zero-extended for
//              BU/HU/WU/D; 0 for the illegal encoding
module load_extract
    import mem_stage_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_data
);

    logic [63:0] w_shifted;

    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_H:    o_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_D:    o_data = w_shifted;
            F3_BU:   o_data = {56'd0, w_shifted[7:0]};
            F3_HU:   o_data = {48'd0, w_shifted[15:0]};
            F3_WU:   o_data = {32'd0, w_shifted[31:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory / write-back pipeline stage.
//   CLK, RST          : clock (rising edge), synchronous active-high reset
//   alu_res           : write-back value, or effective address for memory ops
//   alu_write_back_en : write-back request for non-memory ops
//   rd_i              : destination register
//   load_flag_i       : 1 = load, 0 = store (with mem_en_i)
//   mem_en_i          : memory op present
//   funct3            : access size / signedness
//   store_data        : rs2 value for stores
//   mem               : data-memory bus (master side)
//   stall             : upstream must hold its inputs (combinational)
//   wb_en/wb_rd/wb_data : register-file write port
//   bus_err           : one-cycle pulse on misaligned/illegal access or timeout
// Non-memory ops reach write-back one cycle later. Aligned memory ops are
// latched and issued from REQ until mem_ready or TIMEOUT cycles elapse.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [XLEN-1:0]   alu_res,
    input  logic              alu_write_back_en,
    input  logic [4:0]        rd_i,
    input  logic              load_flag_i,
    input  logic              mem_en_i,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   store_data,
    mem_stage_if.master       mem,
    output logic              stall,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              bus_err
);

    // The counter only needs to reach TIMEOUT-1: that is the last REQ cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [0:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_we;
    logic            r_load;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [7:0]      r_wstrb;
    logic [4:0]      r_rd;
    logic [2:0]      r_f3;
    logic [2:0]      r_off;
    logic            r_wb_en;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_bus_err;

    logic [2:0]      w_off;
    logic            w_aligned;
    logic            w_idle;
    logic            w_in_req;
    logic            w_issue;
    logic            w_timeout;
    logic [63:0]     w_ext;

    assign w_off     = alu_res[2:0];
    assign w_aligned = is_aligned(funct3, w_off);
    assign w_idle    = (r_state == ST_IDLE);
    assign w_in_req  = (r_state == ST_REQ);
    assign w_issue   = w_idle && mem_en_i && w_aligned;
    // mem_ready wins over timeout on the last REQ cycle.
    assign w_timeout = w_in_req && !mem.mem_ready && (r_cnt == CNT_LAST);

    load_extract u_load_extract (
        .i_rdata  (mem.mem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_data   (w_ext)
    );

    // A rejected access does not stall: it retires at once as a bus error.
    assign stall = w_issue || (w_in_req && !mem.mem_ready && !w_timeout);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_load    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rd      <= '0;
            r_f3      <= '0;
            r_off     <= '0;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_wb_en   <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!mem_en_i) begin
                        r_wb_en   <= alu_write_back_en;
                        r_wb_rd   <= rd_i;
                        r_wb_data <= alu_res;
                    end else if (w_aligned) begin
                        r_state <= ST_REQ;
                        r_cnt   <= '0;
                        r_we    <= !load_flag_i;
                        r_load  <= load_flag_i;
                        r_addr  <= {alu_res[XLEN-1:3], 3'b000};
                        r_wdata <= store_data << {w_off, 3'b000};
                        r_wstrb <= byte_strobe(funct3, w_off);
                        r_rd    <= rd_i;
                        r_f3    <= funct3;
                        r_off   <= w_off;
                    end else begin
                        r_bus_err <= 1'b1;
                    end
                end
                default: begin
                    if (mem.mem_ready) begin
                        r_state <= ST_IDLE;
                        if (r_load) begin
                            r_wb_en   <= 1'b1;
                            r_wb_rd   <= r_rd;
                            r_wb_data <= w_ext;
                        end
                    end else if (w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Request fields come straight from the latch, so they stay stable for
    // the whole REQ phase regardless of what upstream presents.
    assign mem.mem_req   = w_in_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_wstrb = r_wstrb;

    assign wb_en   = r_wb_en;
    assign wb_rd   = r_wb_rd;
    assign wb_data = r_wb_data;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// back-to-back op stream checked against a byte-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TB_TIMEOUT = 4;

    logic        CLK;
    logic        RST;
    logic [63:0] alu_res;
    logic        alu_write_back_en;
    logic [4:0]  rd_i;
    logic        load_flag_i;
    logic        mem_en_i;
    logic [2:0]  funct3;
    logic [63:0] store_data;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_if #(.XLEN(64)) mem_bus ();

    mem_stage #(.XLEN(64), .TIMEOUT(TB_TIMEOUT)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .alu_res           (alu_res),
        .alu_write_back_en (alu_write_back_en),
        .rd_i              (rd_i),
        .load_flag_i       (load_flag_i),
        .mem_en_i          (mem_en_i),
        .funct3            (funct3),
        .store_data        (store_data),
        .mem               (mem_bus),
        .stall             (stall),
        .wb_en             (wb_en),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .bus_err           (bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_legal(input logic [2:0] f3, input logic [63:0] a);
        if (f3 == 3'b111) return 1'b0;
        return (int'(a[2:0]) % m_bytes(f3)) == 0;
    endfunction

    function automatic logic [7:0] m_strb(input logic [2:0] f3, input int off);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < m_bytes(f3); i++) s[off + i] = 1'b1;
        return s[7:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] f3, input int off);
        logic [63:0] v;
        int nb;
        nb = m_bytes(f3);
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
        if (!f3[2] && nb < 8 && v[8*nb - 1])
            for (int j = nb; j < 8; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- drive helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        alu_res = '0; alu_write_back_en = 1'b0; rd_i = '0; load_flag_i = 1'b0;
        mem_en_i = 1'b0; funct3 = '0; store_data = '0;
    endtask

    task automatic drive_op(input logic memen, input logic ld, input logic wbe,
                            input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] sd, input logic [4:0] rd);
        mem_en_i = memen; load_flag_i = ld; alu_write_back_en = wbe;
        funct3 = f3; alu_res = a; store_data = sd; rd_i = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        set_idle();
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        tick(); tick();
        RST = 1'b0;
        #1;
        n_tests++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_wstrb} !== 10'd0) begin
            n_fail++; $display("FAIL reset_bus_ctrl: got req=%b we=%b strb=%h want 0", mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_wstrb); end
        n_tests++; if ({mem_bus.mem_addr, mem_bus.mem_wdata} !== 128'd0) begin
            n_fail++; $display("FAIL reset_bus_data: got addr=%h wdata=%h want 0", mem_bus.mem_addr, mem_bus.mem_wdata); end
        n_tests++; if ({stall, wb_en, wb_rd, bus_err} !== 8'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got stall=%b wb_en=%b wb_rd=%0d bus_err=%b want 0", stall, wb_en, wb_rd, bus_err); end
        n_tests++; if (wb_data !== 64'd0) begin
            n_fail++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    endtask

    task automatic test_passthrough();
        drive_op(1'b0, 1'b0, 1'b1, 3'b000, 64'h1234, 64'h0, 5'd5);
        #1;
        n_tests++; if (stall !== 1'b0) begin
            n_fail++; $display("FAIL pass_stall: got %b want 0", stall); end
        tick();
        set_idle();
        n_tests++; if ({wb_en, wb_rd, wb_data, bus_err} !== {1'b1, 5'd5, 64'h1234, 1'b0}) begin
            n_fail++; $display("FAIL pass_wb: got en=%b rd=%0d data=%h err=%b want 1/5/1234/0", wb_en, wb_rd, wb_data, bus_err); end
        tick();
        n_tests++; if (wb_en !== 1'b0) begin
            n_fail++; $display("FAIL pass_wb_clear: got %b want 0", wb_en); end
    endtask

    task automatic test_load_byte();
        int stall_cnt;
        int req_cnt;
        stall_cnt = 0; req_cnt = 0;
        drive_op(1'b1, 1'b1, 1'b0, F3_B, 64'h1003, 64'h0, 5'd7);
        #1;
        if (stall === 1'b1) stall_cnt++;
        tick();
        set_idle();
        n_tests++; if ({mem_bus.mem_addr, mem_bus.mem_we, mem_bus.mem_wstrb} !== {64'h1000, 1'b0, 8'h08}) begin
            n_fail++; $display("FAIL lb_req: got addr=%h we=%b strb=%h want 1000/0/08", mem_bus.mem_addr, mem_bus.mem_we, mem_bus.mem_wstrb); end
        for (int c = 0; c < 4; c++) begin
            mem_bus.mem_ready = (c == 3);
            mem_bus.mem_rdata = (c == 3) ? 64'h00000000_80000000 : 64'hDEAD_BEEF_0000_FFFF;
            #1;
            if (stall === 1'b1) stall_cnt++;
            if (mem_bus.mem_req === 1'b1) req_cnt++;
            tick();
        end
        mem_bus.mem_ready = 1'b0;
        n_tests++; if (stall_cnt !== 4) begin
            n_fail++; $display("FAIL lb_stall_cycles: got %0d want 4", stall_cnt); end
        n_tests++; if (req_cnt !== 4) begin
            n_fail++; $display("FAIL lb_req_cycles: got %0d want 4", req_cnt); end
        n_tests++; if ({wb_en, wb_rd, wb_data, mem_bus.mem_req} !== {1'b1, 5'd7, 64'hFFFFFFFF_FFFFFF80, 1'b0}) begin
            n_fail++; $display("FAIL lb_wb: got en=%b rd=%0d data=%h req=%b want 1/7/ffffffffffffff80/0", wb_en, wb_rd, wb_data, mem_bus.mem_req); end
    endtask

    task automatic test_store_half();
        drive_op(1'b1, 1'b0, 1'b0, F3_H, 64'h2006, 64'hABCD, 5'd9);
        #1;
        n_tests++; if (stall !== 1'b1) begin
            n_fail++; $display("FAIL sh_stall_idle: got %b want 1", stall); end
        tick();
        set_idle();
        mem_bus.mem_ready = 1'b1;
        #1;
        n_tests++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_wstrb, mem_bus.mem_addr, mem_bus.mem_wdata} !==
                       {1'b1, 1'b1, 8'hC0, 64'h2000, 64'hABCD0000_00000000}) begin
            n_fail++; $display("FAIL sh_req: got req=%b we=%b strb=%h addr=%h wdata=%h", mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_wstrb, mem_bus.mem_addr, mem_bus.mem_wdata); end
        n_tests++; if (stall !== 1'b0) begin
            n_fail++; $display("FAIL sh_stall_ready: got %b want 0", stall); end
        tick();
        mem_bus.mem_ready = 1'b0;
        n_tests++; if ({wb_en, mem_bus.mem_req, bus_err} !== 3'b000) begin
            n_fail++; $display("FAIL sh_done: got wb_en=%b req=%b err=%b want 000", wb_en, mem_bus.mem_req, bus_err); end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3s [2];
        logic [63:0] as  [2];
        f3s[0] = F3_W; as[0] = 64'h3002;
        f3s[1] = 3'b111; as[1] = 64'h3000;
        for (int k = 0; k < 2; k++) begin
            drive_op(1'b1, 1'b1, 1'b1, f3s[k], as[k], 64'h0, 5'd3);
            #1;
            n_tests++; if ({stall, mem_bus.mem_req} !== 2'b00) begin
                n_fail++; $display("FAIL mis_issue[%0d]: got stall=%b req=%b want 00", k, stall, mem_bus.mem_req); end
            tick();
            set_idle();
            n_tests++; if ({bus_err, wb_en, mem_bus.mem_req} !== 3'b100) begin
                n_fail++; $display("FAIL mis_err[%0d]: got err=%b wb_en=%b req=%b want 100", k, bus_err, wb_en, mem_bus.mem_req); end
            tick();
            n_tests++; if (bus_err !== 1'b0) begin
                n_fail++; $display("FAIL mis_pulse[%0d]: got %b want 0", k, bus_err); end
        end
    endtask

    task automatic test_timeout();
        int req_cnt;
        int stall_cnt;
        req_cnt = 0; stall_cnt = 0;
        drive_op(1'b1, 1'b1, 1'b0, F3_D, 64'h4000, 64'h0, 5'd4);
        tick();
        set_idle();
        mem_bus.mem_ready = 1'b0;
        for (int c = 0; c < TB_TIMEOUT; c++) begin
            #1;
            if (mem_bus.mem_req === 1'b1) req_cnt++;
            if (stall === 1'b1) stall_cnt++;
            tick();
        end
        n_tests++; if (req_cnt !== TB_TIMEOUT) begin
            n_fail++; $display("FAIL tmo_req_cycles: got %0d want %0d", req_cnt, TB_TIMEOUT); end
        n_tests++; if (stall_cnt !== TB_TIMEOUT - 1) begin
            n_fail++; $display("FAIL tmo_stall_cycles: got %0d want %0d", stall_cnt, TB_TIMEOUT - 1); end
        n_tests++; if ({bus_err, wb_en, mem_bus.mem_req, stall} !== 4'b1000) begin
            n_fail++; $display("FAIL tmo_abort: got err=%b wb_en=%b req=%b stall=%b want 1000", bus_err, wb_en, mem_bus.mem_req, stall); end
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 64'h1111_2222_3333_4444;
        tick();
        mem_bus.mem_ready = 1'b0;
        n_tests++; if ({wb_en, bus_err} !== 2'b00) begin
            n_fail++; $display("FAIL tmo_late_ready: got wb_en=%b err=%b want 00", wb_en, bus_err); end
    endtask

    task automatic test_reset_mid_req();
        drive_op(1'b1, 1'b1, 1'b0, F3_D, 64'h5000, 64'h0, 5'd11);
        tick();
        set_idle();
        mem_bus.mem_ready = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_tests++; if ({mem_bus.mem_req, mem_bus.mem_addr, stall, wb_en, wb_data, bus_err} !== 132'd0) begin
            n_fail++; $display("FAIL rst_mid_req: got req=%b addr=%h stall=%b wb_en=%b data=%h err=%b want 0", mem_bus.mem_req, mem_bus.mem_addr, stall, wb_en, wb_data, bus_err); end
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 64'hCAFE_F00D_1234_5678;
        tick();
        mem_bus.mem_ready = 1'b0;
        n_tests++; if ({wb_en, mem_bus.mem_req} !== 2'b00) begin
            n_fail++; $display("FAIL rst_no_wb: got wb_en=%b req=%b want 00", wb_en, mem_bus.mem_req); end
    endtask

    // Ops are issued back to back: the next op is presented in the cycle
    // right after the previous one retires.
    task automatic test_back_to_back_random();
        int          kind, delay, off, c;
        logic        memen, ld, wbe, legal, rdy, done, tmo;
        logic [2:0]  f3;
        logic [63:0] a, sd, rdat;
        logic [4:0]  rd;
        for (int n = 0; n < 300; n++) begin
            kind  = $urandom_range(0, 2);
            memen = (kind != 0);
            ld    = (kind == 1);
            wbe   = 1'($urandom);
            f3    = 3'($urandom_range(0, 7));
            a     = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a - 64'(int'(a[2:0]) % m_bytes(f3));
            sd    = {$urandom, $urandom};
            rdat  = {$urandom, $urandom};
            rd    = 5'($urandom);
            delay = $urandom_range(0, TB_TIMEOUT + 1);
            off   = int'(a[2:0]);
            legal = memen && m_legal(f3, a);
            drive_op(memen, ld, wbe, f3, a, sd, rd);
            mem_bus.mem_ready = 1'b0;
            #1;
            n_tests++; if (stall !== legal) begin
                n_fail++; $display("FAIL rnd_stall_idle[%0d]: got %b want %b", n, stall, legal); end
            tick();
            if (legal) begin
                done = 1'b0; c = 0; tmo = 1'b0;
                while (!done) begin
                    drive_op(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
                    rdy = (c == delay);
                    mem_bus.mem_ready = rdy;
                    mem_bus.mem_rdata = rdy ? rdat : {$urandom, $urandom};
                    #1;
                    n_tests++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wstrb} !==
                                   {1'b1, !ld, {a[63:3], 3'b000}, sd << (8 * off), m_strb(f3, off)}) begin
                        n_fail++; $display("FAIL rnd_req[%0d.%0d]: got req=%b we=%b addr=%h wdata=%h strb=%h", n, c, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wstrb); end
                    n_tests++; if (stall !== (!rdy && c != TB_TIMEOUT - 1)) begin
                        n_fail++; $display("FAIL rnd_stall_req[%0d.%0d]: got %b", n, c, stall); end
                    tmo  = !rdy && (c == TB_TIMEOUT - 1);
                    done = rdy || tmo;
                    tick();
                    c++;
                end
                mem_bus.mem_ready = 1'b0;
                n_tests++; if ({wb_en, bus_err, mem_bus.mem_req} !== {ld && !tmo, tmo, 1'b0}) begin
                    n_fail++; $display("FAIL rnd_retire[%0d]: got wb_en=%b err=%b req=%b ld=%b tmo=%b", n, wb_en, bus_err, mem_bus.mem_req, ld, tmo); end
                if (ld && !tmo) begin
                    n_tests++; if ({wb_rd, wb_data} !== {rd, m_load(rdat, f3, off)}) begin
                        n_fail++; $display("FAIL rnd_load[%0d]: got rd=%0d data=%h want rd=%0d data=%h (f3=%0d off=%0d)", n, wb_rd, wb_data, rd, m_load(rdat, f3, off), f3, off); end
                end
            end else begin
                n_tests++; if ({wb_en, bus_err, mem_bus.mem_req} !== {!memen && wbe, memen, 1'b0}) begin
                    n_fail++; $display("FAIL rnd_nomem[%0d]: got wb_en=%b err=%b req=%b", n, wb_en, bus_err, mem_bus.mem_req); end
                if (!memen && wbe) begin
                    n_tests++; if ({wb_rd, wb_data} !== {rd, a}) begin
                        n_fail++; $display("FAIL rnd_pass[%0d]: got rd=%0d data=%h want rd=%0d data=%h", n, wb_rd, wb_data, rd, a); end
                end
            end
        end
        set_idle();
    endtask

    initial begin
        RST = 1'b1;
        set_idle();
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory/write-back stage that consumes the registered ALU outputs: result, write-back enable, destination register, load flag and memory enable.
- Non-memory ops pass through to write-back with one cycle of latency.
- Loads and stores are issued on a 64-bit word-addressed data-memory request/ready bus.
- The upstream pipeline is stalled until the access completes, is rejected as misaligned, or times out.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TIMEOUT, 255, max cycles in REQ without mem_ready before the access is aborted.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- alu_res  in  64  ALU result: the write-back value, or the effective address when mem_en_i=1.
- alu_write_back_en  in  1  write-back request for non-memory ops.
- rd_i  in  5  destination register.
- load_flag_i  in  1  with mem_en_i: 1 = load, 0 = store.
- mem_en_i  in  1  memory op present.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- store_data  in  64  rs2 value for stores.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  64  {alu_res[63:3],3'b000}.
- mem_wdata  out  64  store data shifted to the byte lane.
- mem_wstrb  out  8  byte enables.
- mem_ready  in  1  request accepted; mem_rdata valid in the same cycle.
- mem_rdata  in  64  read word.
- stall  out  1  upstream must hold its inputs (combinational).
- wb_en  out  1  register-file write enable.
- wb_rd  out  5  register-file index.
- wb_data  out  64  register-file data.
- bus_err  out  1  one-cycle pulse on misaligned access or timeout.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset applies on any cycle, including mid-REQ: mem_req drops the next cycle and the pending op is discarded with no write-back.
- FSM states: IDLE, REQ.
- IDLE, mem_en_i=0:
  - Next cycle: wb_en=alu_write_back_en, wb_rd=rd_i, wb_data=alu_res.
  - stall=0.
- IDLE, mem_en_i=1, aligned:
  - stall=1 combinationally.
  - Latch address, size, sign, store data, rd and the load flag; enter REQ.
  - wb_en=0 next cycle.
- Alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
- IDLE, mem_en_i=1, misaligned:
  - No request is issued and stall=0.
  - Next cycle: bus_err=1, wb_en=0.
- REQ:
  - mem_req=1; mem_we/addr/wdata/wstrb are held stable until mem_ready.
  - stall = !mem_ready.
  - A cycle counter starts at 0 on REQ entry.
- REQ with mem_ready=1 (cycle K):
  - Return to IDLE.
  - Load: wb_en=1 and wb_rd=latched rd at K+1; wb_data = lane-extracted data, sign-extended for B/H/W and zero-extended for BU/HU/WU/D.
  - Store: wb_en=0.
  - Upstream advances at the end of K; the new op is evaluated in IDLE at K+1. Back-to-back memory ops are legal.
- REQ timeout: the counter reaches TIMEOUT without mem_ready.
  - stall=0 that cycle; return to IDLE.
  - bus_err=1 and wb_en=0 next cycle.
  - mem_ready is ignored after the abort.
- Lane rules, with off = addr[2:0]:
  - mem_wstrb: B = 1<<off; H = 3<<off; W = 8'h0F<<off; D = 8'hFF.
  - mem_wdata = store_data << (8*off).
  - Load extract = mem_rdata >> (8*off), truncated to the access size, then extended.
- wb_rd=0 with wb_en=1 is passed through unchanged; the register file discards x0 writes.
- mem_en_i=1 with funct3=111 is illegal: treat as misaligned (bus_err, no request).

Decomposition:
- Package mem_stage_pkg:
  - funct3 size constants: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - State encoding: ST_IDLE, ST_REQ.
  - Byte-strobe base constants.
- Sub-module load_extract (combinational): rdata + off + funct3 -> 64-bit extended value. Unit-testable on its own.

Test Plan:
- Passthrough: alu_res=0x1234, rd_i=5, write-back 1, mem_en 0 -> next cycle wb_en=1, wb_rd=5, wb_data=0x1234; stall never 1.
- Signed byte load: addr=0x1003, funct3=000, mem_ready after 3 REQ cycles, mem_rdata=0x00000000_80000000 -> stall high for 4 cycles, mem_addr=0x1000, wb_data=0xFFFFFFFF_FFFFFF80.
- Half store: addr=0x2006, funct3=001, store_data=0xABCD -> mem_we=1, mem_wstrb=8'hC0, mem_wdata=0xABCD0000_00000000; wb_en stays 0.
- Misaligned word: addr=0x3002, funct3=010 -> mem_req never 1, stall 0, bus_err pulse next cycle, wb_en=0.
- Timeout: TIMEOUT=4, mem_ready held 0 -> mem_req high for 4 cycles, then bus_err pulse, stall drops, FSM in IDLE.
- Reset mid-REQ: RST=1 in the second REQ cycle -> next cycle mem_req=0, all outputs 0; a later mem_ready causes no write-back.
